// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces presses and releases, and latches one key code per press.
//
// Ports:
//   clk       - single clock, all logic on its rising edge
//   rst_n     - synchronous active-low reset
//   row       - asynchronous keypad row lines, low = key closed
//   col       - active-low one-hot column drive
//   key_code  - last accepted key, row_idx*4 + col_idx
//   key_valid - key_code holds an unread key
//   key_rd    - consumer read strobe, honoured only while key_valid=1
//   key_held  - an accepted key is still pressed
//   overrun   - sticky: an unread key was overwritten
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 4096,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_rd,
    output logic       key_held,
    output logic       overrun
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       row_meta;
    logic [3:0]       rs;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [1:0]       col_idx_nxt;
    logic [3:0]       cand;
    logic [3:0]       cand_nxt;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_nxt;
    logic [DEB_W-1:0] rel_cnt;
    logic [DEB_W-1:0] rel_nxt;
    logic             sample_c;
    logic             hit_c;
    logic [1:0]       hit_row_c;
    logic             accept_c;

    assign sample_c = (div_cnt == DIV_LAST);
    assign hit_c    = ~(&rs);

    // Lowest-index closed row wins when several rows are low.
    always_comb begin
        hit_row_c = 2'd3;
        if (!rs[2]) hit_row_c = 2'd2;
        if (!rs[1]) hit_row_c = 2'd1;
        if (!rs[0]) hit_row_c = 2'd0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_SCAN;
        else        state <= state_nxt;
    end

    // Next-state: decisions are taken only at sample points.
    always_comb begin
        state_nxt   = state;
        col_idx_nxt = col_idx;
        cand_nxt    = cand;
        deb_nxt     = deb_cnt;
        rel_nxt     = rel_cnt;
        accept_c    = 1'b0;
        if (sample_c) begin
            case (state)
                S_SCAN: begin
                    if (hit_c) begin
                        cand_nxt = {hit_row_c, col_idx};
                        if (DEB_W'(1) == DEB_DONE) begin
                            accept_c  = 1'b1;
                            state_nxt = S_HELD;
                            deb_nxt   = '0;
                            rel_nxt   = '0;
                        end else begin
                            state_nxt = S_DEBOUNCE;
                            deb_nxt   = DEB_W'(1);
                        end
                    end else begin
                        col_idx_nxt = 2'(col_idx + 2'd1);
                    end
                end
                S_DEBOUNCE: begin
                    if (hit_c && (hit_row_c == cand[3:2])) begin
                        deb_nxt = DEB_W'(deb_cnt + DEB_W'(1));
                        if (deb_nxt == DEB_DONE) begin
                            accept_c  = 1'b1;
                            state_nxt = S_HELD;
                            deb_nxt   = '0;
                            rel_nxt   = '0;
                        end
                    end else begin
                        state_nxt   = S_SCAN;
                        col_idx_nxt = 2'(col_idx + 2'd1);
                        deb_nxt     = '0;
                    end
                end
                S_HELD: begin
                    if (hit_c) begin
                        rel_nxt = '0;
                    end else begin
                        rel_nxt = DEB_W'(rel_cnt + DEB_W'(1));
                        if (rel_nxt == DEB_DONE) begin
                            state_nxt   = S_SCAN;
                            col_idx_nxt = 2'(col_idx + 2'd1);
                            rel_nxt     = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = S_SCAN;
                end
            endcase
        end
    end

    // Datapath, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta  <= 4'hF;
            rs        <= 4'hF;
            div_cnt   <= '0;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            cand      <= 4'h0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
            div_cnt  <= sample_c ? '0 : DIV_W'(div_cnt + DIV_W'(1));
            col_idx  <= col_idx_nxt;
            col      <= ~(4'b0001 << col_idx_nxt);
            cand     <= cand_nxt;
            deb_cnt  <= deb_nxt;
            rel_cnt  <= rel_nxt;
            key_held <= (state_nxt == S_HELD);
            if (accept_c) begin
                key_code  <= cand_nxt;
                key_valid <= 1'b1;
                // A same-cycle read consumes the old key, so nothing is lost.
                if (key_valid) overrun <= ~key_rd;
            end else if (key_rd && key_valid) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4096: clk cycles per column dwell/sample period, min 2.
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 8: consecutive matching samples needed to accept a press or a release, min 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port row, input, 4 bits: keypad row lines, asynchronous, active-low (pulled up, low = key closed).
REQ-006 The block SHALL have port col, output, 4 bits: keypad column drive, active-low one-hot.
REQ-007 The block SHALL have port key_code, output, 4 bits: last accepted key, code = row_idx*4 + col_idx.
REQ-008 The block SHALL have port key_valid, output, 1 bit: key_code holds an unread key.
REQ-009 The block SHALL have port key_rd, input, 1 bit: consumer read strobe, effective only while key_valid=1.
REQ-010 The block SHALL have port key_held, output, 1 bit: an accepted key is still pressed.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag, an unread key was overwritten.

Function
REQ-012 row SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-013 Period counter div_cnt SHALL count 0..SCAN_DIV-1 and wrap; the sample point is div_cnt==SCAN_DIV-1.
REQ-014 col SHALL equal ~(1<<col_idx) at all times; col_idx SHALL change only at a sample point.
REQ-015 Hit = any bit of rs low; hit row = lowest-index low bit of rs; multiple low rows resolve to the lowest index.
REQ-016 FSM states SHALL be SCAN, DEBOUNCE and HELD.
REQ-017 SCAN: at a sample point with no hit, col_idx SHALL advance (3 wraps to 0); with a hit, candidate = {hit row, col_idx}, deb_cnt=1, column frozen, next state DEBOUNCE.
REQ-018 DEBOUNCE: at each sample point with the same hit row, deb_cnt SHALL increment; any other sample SHALL return to SCAN and advance col_idx.
REQ-019 When deb_cnt reaches DEBOUNCE_CNT, the block SHALL accept: load key_code=candidate, set key_valid, go to HELD; DEBOUNCE_CNT=1 accepts on the initial SCAN hit.
REQ-020 HELD: key_held=1 and the column stays frozen.
REQ-021 HELD: each sample with no hit SHALL increment rel_cnt; any hit SHALL clear rel_cnt.
REQ-022 HELD: when rel_cnt reaches DEBOUNCE_CNT, the FSM SHALL go to SCAN, advance col_idx, and clear key_held.
REQ-023 A held key SHALL produce exactly one accept, regardless of hold duration.
REQ-024 key_rd while key_valid=1 SHALL clear key_valid and overrun on the next edge; key_rd while key_valid=0 SHALL have no effect.
REQ-025 An accept while key_valid=1 without a same-cycle key_rd SHALL overwrite key_code, keep key_valid=1, and set overrun.
REQ-026 An accept coincident with key_rd SHALL load the new key_code, keep key_valid=1, and clear overrun.
REQ-027 Press latency SHALL be at most 2 sync cycles + 4*SCAN_DIV (column search) + (DEBOUNCE_CNT-1)*SCAN_DIV cycles.
REQ-028 key_valid SHALL assert on the accept edge, at a sample point +1 cycle.

Reset
REQ-029 On rst_n=0 at a rising clk edge: state=SCAN, div_cnt=0, col_idx=0, col=4'b1110, deb_cnt=0, rel_cnt=0, synchronizer=4'b1111.
REQ-030 On the same edge: key_code=4'h0, key_valid=0, key_held=0, overrun=0.
REQ-031 Reset in any state, including mid-DEBOUNCE or HELD, SHALL discard the candidate and produce no accept.
REQ-032 The first sample point after reset release SHALL be SCAN_DIV cycles later.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-033 Reset: rst_n=0 for 1 cycle -> col=1110, key_code=0, key_valid=0, key_held=0, overrun=0.
REQ-034 Press row2/col1 steady 200 cycles -> exactly one accept, key_code=4'h9, key_valid=1, key_held=1, col frozen at 1101; release -> key_held=0 after 3 clean samples, scan resumes at col 1011.
REQ-035 Bounce: row0 low for 2 samples on col 0, then high -> no key_valid, col advances to 1101.
REQ-036 Overrun: accept 4'h9, no key_rd, release, press row3/col3 -> key_code=4'hF, key_valid=1, overrun=1; key_rd -> key_valid=0, overrun=0.
REQ-037 Accept coincident with key_rd -> key_valid stays 1, overrun=0, key_code = new key.
REQ-038 rst_n=0 during DEBOUNCE with row still low -> col=1110, no key_valid; after release of rst_n, the held key is accepted as a fresh press.
